// File: rtl/meter_pkg.sv
// Shared constants and state encoding for the parking-meter countdown block.
package meter_pkg;

    // Counter range and the LOW/RUN boundary
    localparam logic [13:0] MAX_TIME   = 14'd9999;
    localparam logic [13:0] LOW_THRESH = 14'd200;

    // Seconds added by each button pulse
    localparam logic [13:0] ADD_U = 14'd10;
    localparam logic [13:0] ADD_L = 14'd180;
    localparam logic [13:0] ADD_R = 14'd200;
    localparam logic [13:0] ADD_D = 14'd550;

    // Values forced while a preset switch is held
    localparam logic [13:0] PRESET_SW0 = 14'd10;
    localparam logic [13:0] PRESET_SW1 = 14'd205;

    typedef enum logic [1:0] {
        EXPIRED = 2'd0,
        LOW     = 2'd1,
        RUN     = 2'd2
    } meter_state_t;

endpackage

// File: rtl/meter_ctrl_bin2bcd14.sv
// Combinational double-dabble: 14-bit binary (0..9999) to four BCD digits.
module bin2bcd14 (
    input  logic [13:0] bin,
    output logic [15:0] bcd
);

    logic [29:0] shift_reg_next;

    // Shift-and-add-3: correct every BCD nibble >= 5 before each left shift
    always_comb begin
        shift_reg_next = {16'd0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (shift_reg_next[14 + 4*d +: 4] >= 4'd5) begin
                    shift_reg_next[14 + 4*d +: 4] = shift_reg_next[14 + 4*d +: 4] + 4'd3;
                end
            end
            shift_reg_next = shift_reg_next << 1;
        end
    end

    assign bcd = shift_reg_next[29:14];

endmodule

// File: rtl/meter_ctrl.sv
// Parking-meter countdown sequencer: saturating seconds counter with button
// adds, preset switches, 1 Hz decrement and display flash control.
// Optional feature macro: METER_LOW_FLASH_EN (0.5 Hz flash in the LOW state).
module meter_ctrl
    import meter_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse_btnu,
    input  logic        pulse_btnl,
    input  logic        pulse_btnr,
    input  logic        pulse_btnd,
    input  logic        sw0,
    input  logic        sw1,
    output logic [13:0] time_bin,
    output logic [15:0] digits,
    output logic        blank,
    output logic        expired
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2 - 1);

    logic [CNT_W-1:0] sec_cnt_reg;
    logic [1:0]       phase_reg;
    logic [13:0]      time_reg, time_next;
    logic [15:0]      digits_reg, bcd_next;
    logic             blank_reg, blank_next;
    meter_state_t     state_reg, state_next;
    logic             tick, half, preset, dec;
    logic [14:0]      add_sum, sum_next;

    assign preset = sw0 | sw1;
    assign tick   = (sec_cnt_reg == CNT_LAST);
    assign half   = (sec_cnt_reg == CNT_HALF) || tick;
    assign dec    = tick && (time_reg != 14'd0);

    // Second prescaler and flash phase; both frozen at zero while a preset is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt_reg <= '0;
            phase_reg   <= 2'd0;
        end else if (preset) begin
            sec_cnt_reg <= '0;
            phase_reg   <= 2'd0;
        end else begin
            sec_cnt_reg <= tick ? '0 : sec_cnt_reg + 1'b1;
            if (half) begin
                phase_reg <= phase_reg + 2'd1;
            end
        end
    end

    // Next time value: presets win, otherwise add pulses, subtract tick, saturate
    always_comb begin
        add_sum = 15'd0;
        if (pulse_btnu) add_sum = add_sum + {1'b0, ADD_U};
        if (pulse_btnl) add_sum = add_sum + {1'b0, ADD_L};
        if (pulse_btnr) add_sum = add_sum + {1'b0, ADD_R};
        if (pulse_btnd) add_sum = add_sum + {1'b0, ADD_D};
        sum_next = {1'b0, time_reg} + add_sum - {14'd0, dec};
        if (sw0) begin
            time_next = PRESET_SW0;
        end else if (sw1) begin
            time_next = PRESET_SW1;
        end else if (sum_next > {1'b0, MAX_TIME}) begin
            time_next = MAX_TIME;
        end else begin
            time_next = sum_next[13:0];
        end
    end

    // Time register and the registered BCD image of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_reg   <= 14'd0;
            digits_reg <= 16'd0;
        end else begin
            time_reg   <= time_next;
            digits_reg <= bcd_next;
        end
    end

    bin2bcd14 u_bcd (
        .bin (time_reg),
        .bcd (bcd_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EXPIRED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state is classified from the upcoming time value
    always_comb begin
        if (time_next == 14'd0) begin
            state_next = EXPIRED;
        end else if (time_next < LOW_THRESH) begin
            state_next = LOW;
        end else begin
            state_next = RUN;
        end
    end

    // Flash decode: EXPIRED flashes at 1 Hz, LOW optionally at 0.5 Hz
    always_comb begin
        blank_next = 1'b0;
        case (state_reg)
            EXPIRED: blank_next = phase_reg[0];
`ifdef METER_LOW_FLASH_EN
            LOW:     blank_next = phase_reg[1];
`else
            LOW:     blank_next = 1'b0;
`endif
            default: blank_next = 1'b0;
        endcase
    end

    // Registered blank so the display sees a glitch-free flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_reg <= 1'b0;
        end else begin
            blank_reg <= blank_next;
        end
    end

    assign time_bin = time_reg;
    assign digits   = digits_reg;
    assign blank    = blank_reg;
    assign expired  = (state_reg == EXPIRED);

endmodule
